uart_tx_cfg: RTL and testbench

UART_TX_CFG -- requirements
Module: uart_tx_cfg

---
 rtl/uart_pkg.sv | 41 ++++
 rtl/uart_fifo.sv | 50 +++++
 rtl/uart_tx_cfg.sv | 167 ++++++++++++++++
 tb/tb_uart_tx_cfg.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART encodings: character length, parity mode, frame FSM states and latched frame config.
package uart_pkg;

    typedef enum logic [1:0] {
        DB_5 = 2'b00,
        DB_6 = 2'b01,
        DB_7 = 2'b10,
        DB_8 = 2'b11
    } data_bits_t;

    typedef enum logic [1:0] {
        PAR_NONE     = 2'b00,
        PAR_EVEN     = 2'b01,
        PAR_ODD      = 2'b10,
        PAR_NONE_ALT = 2'b11
    } parity_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_t;

    typedef struct packed {
        data_bits_t bits;
        parity_t    parity;
        logic       stop2;
    } frame_cfg_t;

    // Index of the last data bit: 5 bits -> 4 ... 8 bits -> 7.
    function automatic logic [2:0] last_bit_idx(data_bits_t db);
        return 3'd4 + 3'(db);
    endfunction

    function automatic logic parity_on(parity_t p);
        return (p == PAR_EVEN) || (p == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// Byte FIFO with power-of-two depth; head entry is visible on rd_data while non-empty.
module uart_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [7:0]               wr_data,
    input  logic                     pop,
    output logic [7:0]               rd_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign push_ok = push && (count < CW'(DEPTH));
    assign pop_ok  = pop && (count != '0);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: FIFO-fed, 5..8 data bits, optional even/odd parity, 1 or 2 stop bits.
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int unsigned CLOCK_FREQUENCY = 100000000,
    parameter int unsigned BAUD_RATE       = 9600,
    parameter int unsigned FIFO_DEPTH      = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [7:0]                    data,
    input  logic                          valid,
    output logic                          ready,
    input  logic [1:0]                    data_bits,
    input  logic [1:0]                    parity_mode,
    input  logic                          stop_bits,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int unsigned DIVISOR = CLOCK_FREQUENCY / BAUD_RATE;
    localparam int unsigned BW      = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
    localparam int unsigned CW      = $clog2(FIFO_DEPTH) + 1;

    uart_state_t state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic          stop_idx_q, stop_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    frame_cfg_t    cfg_q, cfg_d;
    logic          tx_d;
    logic          busy_d;
    logic          bit_done;
    logic          start_frame;
    logic          push;
    logic          pop;
    logic [7:0]    fifo_rd;
    logic [CW-1:0] count_d;

    assign ready    = (fifo_count < CW'(FIFO_DEPTH));
    assign push     = valid && ready;
    assign bit_done = (baud_q == BW'(DIVISOR - 1));

    uart_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push    (push),
        .wr_data (data),
        .pop     (pop),
        .rd_data (fifo_rd),
        .count   (fifo_count)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            baud_q     <= '0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            cfg_q      <= '0;
            tx         <= 1'b1;
            busy       <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_idx_q  <= bit_idx_d;
            stop_idx_q <= stop_idx_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            cfg_q      <= cfg_d;
            tx         <= tx_d;
            busy       <= busy_d;
        end
    end

    // Next-state, line value and frame bookkeeping; tx_d is the line level for the coming cycle.
    always_comb begin
        state_d     = state_q;
        baud_d      = baud_q;
        bit_idx_d   = bit_idx_q;
        stop_idx_d  = stop_idx_q;
        shift_d     = shift_q;
        par_d       = par_q;
        cfg_d       = cfg_q;
        tx_d        = tx;
        pop         = 1'b0;
        start_frame = 1'b0;

        if (state_q != ST_IDLE) begin
            baud_d = bit_done ? '0 : baud_q + BW'(1);
        end

        case (state_q)
            ST_IDLE: begin
                start_frame = (fifo_count != '0);
            end
            ST_START: begin
                if (bit_done) begin
                    state_d = ST_DATA;
                    tx_d    = shift_q[0];
                end
            end
            ST_DATA: begin
                if (bit_done) begin
                    par_d   = par_q ^ shift_q[0];
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_idx_q == last_bit_idx(cfg_q.bits)) begin
                        if (parity_on(cfg_q.parity)) begin
                            state_d = ST_PARITY;
                            tx_d    = par_d ^ (cfg_q.parity == PAR_ODD);
                        end else begin
                            state_d = ST_STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_d      = shift_q[1];
                    end
                end
            end
            ST_PARITY: begin
                if (bit_done) begin
                    state_d = ST_STOP;
                    tx_d    = 1'b1;
                end
            end
            ST_STOP: begin
                if (bit_done) begin
                    if (stop_idx_q == cfg_q.stop2) begin
                        if (fifo_count != '0) begin
                            start_frame = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        stop_idx_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
            end
        endcase

        // Back-to-back frames start on the same edge the previous stop bit ends.
        if (start_frame) begin
            pop        = 1'b1;
            cfg_d      = '{bits: data_bits_t'(data_bits), parity: parity_t'(parity_mode), stop2: stop_bits};
            shift_d    = fifo_rd;
            par_d      = 1'b0;
            bit_idx_d  = '0;
            stop_idx_d = 1'b0;
            state_d    = ST_START;
            tx_d       = 1'b0;
        end

        count_d = fifo_count + CW'(push) - CW'(pop);
        busy_d  = (state_d != ST_IDLE) || (count_d != '0);
    end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Randomized and directed bench for uart_tx_cfg against a frame-level line model.
module tb_uart_tx_cfg;

    localparam int unsigned DIV   = 10;
    localparam int unsigned DEPTH = 4;

    logic       clock;
    logic       reset;
    logic [7:0] data;
    logic       valid;
    logic       ready;
    logic [1:0] data_bits;
    logic [1:0] parity_mode;
    logic       stop_bits;
    logic       tx;
    logic       busy;
    logic [2:0] fifo_count;

    int n_compared;
    int n_mismatched;

    logic [7:0] fifo_q[$];
    logic       line_q[$];
    logic       tx_log[$];

    uart_tx_cfg #(
        .CLOCK_FREQUENCY (1000),
        .BAUD_RATE       (100),
        .FIFO_DEPTH      (DEPTH)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .data        (data),
        .valid       (valid),
        .ready       (ready),
        .data_bits   (data_bits),
        .parity_mode (parity_mode),
        .stop_bits   (stop_bits),
        .tx          (tx),
        .busy        (busy),
        .fifo_count  (fifo_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Appends one whole frame (DIV samples per bit) built from the character rules.
    task automatic build_frame(input logic [7:0] b);
        logic bits[$];
        int   nd;
        logic p;
        nd = 5 + int'(data_bits);
        p  = 1'b0;
        bits.push_back(1'b0);
        for (int i = 0; i < nd; i++) begin
            bits.push_back(b[i]);
            p ^= b[i];
        end
        if (parity_mode == 2'b01) bits.push_back(p);
        if (parity_mode == 2'b10) bits.push_back(~p);
        bits.push_back(1'b1);
        if (stop_bits) bits.push_back(1'b1);
        foreach (bits[i]) begin
            for (int k = 0; k < int'(DIV); k++) line_q.push_back(bits[i]);
        end
    endtask

    // One clock: update the model from the inputs at this edge, then compare the outputs.
    task automatic tick();
        logic exp_tx;
        logic in_frame;
        logic start_now;
        logic accept;
        if (reset) begin
            fifo_q.delete();
            line_q.delete();
        end else begin
            start_now = (line_q.size() == 0) && (fifo_q.size() != 0);
            accept    = valid && (fifo_q.size() < DEPTH);
            if (start_now) build_frame(fifo_q.pop_front());
            if (accept) fifo_q.push_back(data);
        end
        @(posedge clock);
        #1;
        if (line_q.size() != 0) begin
            exp_tx   = line_q.pop_front();
            in_frame = 1'b1;
        end else begin
            exp_tx   = 1'b1;
            in_frame = 1'b0;
        end
        check_eq("tx", 32'(tx), 32'(exp_tx));
        check_eq("fifo_count", 32'(fifo_count), 32'(fifo_q.size()));
        check_eq("busy", 32'(busy), 32'(in_frame || (fifo_q.size() != 0)));
        check_eq("ready", 32'(ready), 32'(fifo_q.size() < DEPTH));
        tx_log.push_back(tx);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((line_q.size() != 0 || fifo_q.size() != 0) && n < 3000) begin
            tick();
            n++;
        end
        tick();
        check_eq({tag, "_idle"}, 32'(busy), 32'(0));
    endtask

    // Samples the middle of each bit of a frame starting at log index start.
    task automatic check_frame(input string tag, input int start, input logic [15:0] pat, input int nbits);
        for (int b = 0; b < nbits; b++) begin
            int idx;
            idx = start + b * int'(DIV) + int'(DIV) / 2;
            if (idx < tx_log.size()) check_eq(tag, 32'(tx_log[idx]), 32'(pat[b]));
            else                     check_eq({tag, "_short"}, 32'(tx_log.size()), 32'(idx + 1));
        end
    endtask

    task automatic push_one(input logic [7:0] b);
        data  = b;
        valid = 1'b1;
        tick();
        valid = 1'b0;
    endtask

    task automatic set_cfg(input logic [1:0] db, input logic [1:0] pm, input logic sb);
        data_bits   = db;
        parity_mode = pm;
        stop_bits   = sb;
    endtask

    initial begin
        int start;
        n_compared   = 0;
        n_mismatched = 0;
        reset = 1'b1;
        data  = '0;
        valid = 1'b0;
        set_cfg(2'b11, 2'b00, 1'b0);
        tick();
        tick();
        reset = 1'b0;
        tick();

        // 0x55, 8N1
        start = tx_log.size() + 1;
        push_one(8'h55);
        repeat (110) tick();
        check_frame("frame_55_8n1", start, 16'h02AA, 10);
        drain("f55");

        // 0x07, 7 bits, even parity, 2 stop
        set_cfg(2'b10, 2'b01, 1'b1);
        start = tx_log.size() + 1;
        push_one(8'h07);
        repeat (115) tick();
        check_frame("frame_07_7e2", start, 16'h070E, 11);
        drain("f07e");

        // 5 bits, odd parity; upper data bits must not appear on the line
        set_cfg(2'b00, 2'b10, 1'b0);
        start = tx_log.size() + 1;
        push_one(8'hE7);
        repeat (85) tick();
        check_frame("frame_e7_5o1", start, 16'h008E, 8);
        drain("f5o");

        // Six back-to-back pushes: FIFO fills, extras rejected, frames contiguous
        set_cfg(2'b11, 2'b00, 1'b0);
        valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            data = 8'(8'hA0 + i);
            tick();
        end
        valid = 1'b0;
        drain("b2b");

        // Reset during cycle 35 of a frame
        set_cfg(2'b11, 2'b01, 1'b0);
        push_one(8'h3C);
        repeat (35) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("rst_tx", 32'(tx), 32'(1));
        check_eq("rst_count", 32'(fifo_count), 32'(0));
        repeat (150) tick();
        check_eq("rst_no_restart", 32'(busy), 32'(0));

        // Parity mode change mid-frame affects only the next frame
        set_cfg(2'b11, 2'b01, 1'b0);
        push_one(8'h5A);
        push_one(8'h5A);
        repeat (40) tick();
        parity_mode = 2'b10;
        drain("par_chg");

        // Random traffic with random configuration changes
        for (int i = 0; i < 3000; i++) begin
            valid = ($urandom_range(0, 7) == 0);
            data  = 8'($urandom);
            if ($urandom_range(0, 49) == 0) begin
                set_cfg(2'($urandom), 2'($urandom), 1'($urandom));
            end
            tick();
        end
        valid = 1'b0;
        drain("rand");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
